// File: rtl/ibex_pkg.sv
// Shared opcode constants plus the RVC encodings and helpers used by the compressed packer.
package ibex_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned HALF_W  = 16;

    typedef enum logic [6:0] {
        OPCODE_LOAD   = 7'h03,
        OPCODE_OP_IMM = 7'h13,
        OPCODE_STORE  = 7'h23,
        OPCODE_OP     = 7'h33,
        OPCODE_JALR   = 7'h67,
        OPCODE_SYSTEM = 7'h73
    } opcode_e;

    localparam logic [HALF_W-1:0] RVC_NOP    = 16'h0001;
    localparam logic [HALF_W-1:0] RVC_EBREAK = 16'h9002;

    // Packed output word: lo sits at the lower address.
    typedef struct packed {
        logic [HALF_W-1:0] hi;
        logic [HALF_W-1:0] lo;
    } pack_word_t;

    // True for the x8..x15 registers reachable through 3-bit RVC register fields.
    function automatic logic is_creg(input logic [4:0] r);
        return r[4:3] == 2'b01;
    endfunction

endpackage

// File: rtl/ibex_compressed_encoder.sv
// Combinational RV32I -> RVC encoder; first matching rule wins, otherwise comp_o = 0.
module ibex_compressed_encoder
    import ibex_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output logic               comp_o,
    output logic [HALF_W-1:0]  instr16_o
);

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm_i;
    logic [11:0] imm_s;
    logic        imm_small;
    logic        ld_off_ok;
    logic        st_off_ok;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign funct7 = instr_i[31:25];
    assign imm_i  = instr_i[31:20];
    assign imm_s  = {instr_i[31:25], instr_i[11:7]};

    // Sign-extended 6-bit range [-32,31]: bits 11..5 all equal.
    assign imm_small = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7f);
    // Word-aligned offset in [0,124].
    assign ld_off_ok = (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'd0);
    assign st_off_ok = (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'd0);

    always_comb begin
        comp_o    = 1'b0;
        instr16_o = '0;
        if (instr_i == 32'h0010_0073) begin
            comp_o    = 1'b1;
            instr16_o = RVC_EBREAK;
        end else if (instr_i == 32'h0000_0013) begin
            comp_o    = 1'b1;
            instr16_o = RVC_NOP;
        end else if (opcode == OPCODE_OP_IMM && funct3 == 3'b000 && rd != 5'd0 &&
                     rs1 == rd && imm_small && imm_i != 12'd0) begin
            comp_o    = 1'b1;
            instr16_o = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (opcode == OPCODE_OP_IMM && funct3 == 3'b000 && rd != 5'd0 &&
                     rs1 == 5'd0 && imm_small) begin
            comp_o    = 1'b1;
            instr16_o = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (opcode == OPCODE_OP && funct3 == 3'b000 && funct7 == 7'd0 &&
                     rd != 5'd0 && rs1 == 5'd0 && rs2 != 5'd0) begin
            comp_o    = 1'b1;
            instr16_o = {3'b100, 1'b0, rd, rs2, 2'b10};
        end else if (opcode == OPCODE_OP && funct3 == 3'b000 && funct7 == 7'd0 &&
                     rd != 5'd0 && rs1 == rd && rs2 != 5'd0) begin
            comp_o    = 1'b1;
            instr16_o = {3'b100, 1'b1, rd, rs2, 2'b10};
        end else if (opcode == OPCODE_LOAD && funct3 == 3'b010 && is_creg(rd) &&
                     is_creg(rs1) && ld_off_ok) begin
            comp_o    = 1'b1;
            instr16_o = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
        end else if (opcode == OPCODE_STORE && funct3 == 3'b010 && is_creg(rs2) &&
                     is_creg(rs1) && st_off_ok) begin
            comp_o    = 1'b1;
            instr16_o = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
        end else if (opcode == OPCODE_JALR && funct3 == 3'b000 && rd == 5'd0 &&
                     imm_i == 12'd0 && rs1 != 5'd0) begin
            comp_o    = 1'b1;
            instr16_o = {3'b100, 1'b0, rs1, 5'd0, 2'b10};
        end
    end

endmodule

// File: rtl/ibex_compressed_packer.sv
// Streams RV32 instructions through the RVC encoder and packs parcels into 32-bit words.
// Optional statistics counters are enabled with IBEX_CPACK_STATS_EN.
module ibex_compressed_packer
    import ibex_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [INSTR_W-1:0] in_instr_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [INSTR_W-1:0] out_word_o,
    output logic               busy_o,
    output logic [31:0]        cnt_total_o,
    output logic [31:0]        cnt_comp_o
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HALF  = 1'b1;

    logic              comp;
    logic [HALF_W-1:0] c16;

    ibex_compressed_encoder u_encoder (
        .instr_i   (in_instr_i),
        .comp_o    (comp),
        .instr16_o (c16)
    );

    logic [0:0]        state_q, state_d;
    logic [HALF_W-1:0] residue_q, residue_d;
    logic              out_valid_q, out_valid_d;
    pack_word_t        out_word_q, out_word_d;
    logic              busy_q, busy_d;
    logic              can_load;
    logic              accept;
    logic              produce;

    assign can_load   = !out_valid_q || out_ready_i;
    assign in_ready_o = can_load;
    assign accept     = in_valid_i && can_load;

    // Packing FSM: state tracks whether a lone halfword is waiting for a partner.
    always_comb begin
        state_d    = state_q;
        residue_d  = residue_q;
        out_word_d = out_word_q;
        produce    = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    if (comp) begin
                        state_d   = ST_HALF;
                        residue_d = c16;
                    end else begin
                        produce    = 1'b1;
                        out_word_d = in_instr_i;
                    end
                end
            end
            ST_HALF: begin
                if (accept) begin
                    produce = 1'b1;
                    if (comp) begin
                        out_word_d = '{hi: c16, lo: residue_q};
                        state_d    = ST_EMPTY;
                    end else begin
                        out_word_d = '{hi: in_instr_i[15:0], lo: residue_q};
                        residue_d  = in_instr_i[31:16];
                    end
                end else if (flush_i && can_load) begin
                    produce    = 1'b1;
                    out_word_d = '{hi: RVC_NOP, lo: residue_q};
                    state_d    = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        out_valid_d = produce || (out_valid_q && !out_ready_i);
        busy_d      = (state_d == ST_HALF) || out_valid_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_EMPTY;
            residue_q   <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            residue_q   <= residue_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_word_o  = out_word_q;
    assign busy_o      = busy_q;

`ifdef IBEX_CPACK_STATS_EN
    logic [31:0] cnt_total_q;
    logic [31:0] cnt_comp_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_total_q <= '0;
            cnt_comp_q  <= '0;
        end else if (accept) begin
            cnt_total_q <= cnt_total_q + 32'd1;
            if (comp) begin
                cnt_comp_q <= cnt_comp_q + 32'd1;
            end
        end
    end

    assign cnt_total_o = cnt_total_q;
    assign cnt_comp_o  = cnt_comp_q;
`else
    assign cnt_total_o = 32'h0;
    assign cnt_comp_o  = 32'h0;
`endif

endmodule

// File: tb/tb_ibex_compressed_packer.sv
// Directed-vector bench for ibex_compressed_packer with hand-computed packed words.
module tb_ibex_compressed_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        busy;
    logic [31:0] cnt_total;
    logic [31:0] cnt_comp;

    int n_checks = 0;
    int n_errors = 0;
    int exp_total = 0;
    int exp_comp  = 0;

    ibex_compressed_packer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_instr_i  (in_instr),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_word_o  (out_word),
        .busy_o      (busy),
        .cnt_total_o (cnt_total),
        .cnt_comp_o  (cnt_comp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
`ifdef IBEX_CPACK_STATS_EN
        check({tag, "_total"}, cnt_total, 32'(exp_total));
        check({tag, "_comp"},  cnt_comp,  32'(exp_comp));
`else
        check({tag, "_total"}, cnt_total, 32'h0);
        check({tag, "_comp"},  cnt_comp,  32'h0);
`endif
    endtask

    // Present one instruction for exactly one accepting edge; in_valid stays high afterwards.
    task automatic send(input logic [31:0] instr, input bit compressible);
        in_valid = 1'b1;
        in_instr = instr;
        check("send_ready", {31'd0, in_ready}, 32'd1);
        step();
        exp_total++;
        if (compressible) exp_comp++;
    endtask

    task automatic idle_step();
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset state
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_word",  out_word, 32'h0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check_counts("rst");

        // nop + c.addi pair
        send(32'h0000_0013, 1);
        check("nop_novalid", {31'd0, out_valid}, 32'd0);
        check("nop_busy",    {31'd0, busy}, 32'd1);
        send(32'h0014_0413, 1);
        check("pair_valid", {31'd0, out_valid}, 32'd1);
        check("pair_word",  out_word, 32'h0405_0001);
        idle_step();
        check("pair_drain", {31'd0, out_valid}, 32'd0);
        check("pair_idle",  {31'd0, busy}, 32'd0);
        check_counts("pair");

        // nop + lui splits lui across words; flush pads the residue
        send(32'h0000_0013, 1);
        send(32'h1234_52B7, 0);
        check("split_word", out_word, 32'h52B7_0001);
        check("split_busy", {31'd0, busy}, 32'd1);
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        check("flush_valid", {31'd0, out_valid}, 32'd1);
        check("flush_word",  out_word, 32'h0001_1234);
        flush = 1'b0;
        step();
        check("flush_idle", {31'd0, busy}, 32'd0);

        // c.mv + c.ebreak
        send(32'h00B0_0533, 1);
        send(32'h0010_0073, 1);
        check("mv_ebreak", out_word, 32'h9002_852E);
        // c.li x10,-1 + c.jr x1
        send(32'hFFF0_0513, 1);
        send(32'h0000_8067, 1);
        check("li_jr", out_word, 32'h8082_557D);
        // c.lw x9,8(x8) + c.sw x9,4(x8)
        send(32'h0084_2483, 1);
        send(32'h0094_2223, 1);
        check("lw_sw", out_word, 32'hC044_4404);
        // c.add x8,x9 + lui leaves lui upper half as residue
        send(32'h0094_0433, 1);
        send(32'h1234_52B7, 0);
        check("add_lui", out_word, 32'h52B7_9426);
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        check("add_flush", out_word, 32'h0001_1234);
        flush = 1'b0;
        step();
        check("add_idle", {31'd0, busy}, 32'd0);
        check_counts("mix");

        // addi imm out of range: passthrough
        send(32'h0204_0413, 0);
        check("pass_valid", {31'd0, out_valid}, 32'd1);
        check("pass_word",  out_word, 32'h0204_0413);
        idle_step();
        check_counts("pass");

        // Backpressure with residue, input and flush all pending
        send(32'h0000_0013, 1);
        send(32'h1234_52B7, 0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0014_0413;
        flush     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_ready", {31'd0, in_ready}, 32'd0);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_word",  out_word, 32'h52B7_0001);
        end
        out_ready = 1'b1;
        step();
        exp_total++;
        exp_comp++;
        check("bp_input_first", out_word, 32'h0405_1234);
        in_valid = 1'b0;
        step();
        check("bp_no_flush", {31'd0, out_valid}, 32'd0);
        check("bp_idle",     {31'd0, busy}, 32'd0);
        flush = 1'b0;
        check_counts("bp");

        // Asynchronous reset mid-stream
        send(32'h0000_0013, 1);
        send(32'h1234_52B7, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_word",  out_word, 32'h0);
        check("arst_busy",  {31'd0, busy}, 32'd0);
        exp_total = 0;
        exp_comp  = 0;
        check_counts("arst");
        step();
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_valid", {31'd0, out_valid}, 32'd0);
            check("post_rst_busy",  {31'd0, busy}, 32'd0);
        end
        flush = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
